// File: rtl/cache_pkg.sv
// Shared types and helpers for the direct-mapped write-back cache.
// Address-field and merge helpers work on wide containers; callers cast to their own widths.
package cache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WB_REQ,
    WB_WAIT,
    RF_REQ,
    RF_WAIT,
    RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam int MAX_AW = 64;
  localparam int MAX_DW = 256;

  // Extract addr[lsb +: width]; width 0 yields 0.
  function automatic logic [MAX_AW-1:0] addr_field(input logic [MAX_AW-1:0] addr,
                                                   input int lsb, input int width);
    logic [MAX_AW-1:0] mask;
    mask = (width >= MAX_AW) ? '1 : ((MAX_AW'(1) << width) - MAX_AW'(1));
    return (addr >> lsb) & mask;
  endfunction

  function automatic logic [MAX_AW-1:0] line_align(input logic [MAX_AW-1:0] addr,
                                                   input int off_bits);
    return addr & ~((MAX_AW'(1) << off_bits) - MAX_AW'(1));
  endfunction

  function automatic logic [MAX_DW-1:0] byte_merge(input logic [MAX_DW-1:0]   word,
                                                   input logic [MAX_DW-1:0]   wdata,
                                                   input logic [MAX_DW/8-1:0] wstrb);
    logic [MAX_DW-1:0] res;
    res = word;
    for (int b = 0; b < MAX_DW/8; b++)
      if (wstrb[b]) res[b*8 +: 8] = wdata[b*8 +: 8];
    return res;
  endfunction

endpackage

// File: rtl/cache_array.sv
// Tag/valid/dirty/data storage: async-reset valid+dirty, synchronous writes, combinational read.
module cache_array
  import cache_pkg::*;
#(
  parameter int TAG_BITS   = 28,
  parameter int IDX_BITS   = 3,
  parameter int NUM_LINES  = 8,
  parameter int DATA_WIDTH = 32,
  parameter int WORDS      = 4,
  parameter int WSEL_BITS  = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [IDX_BITS-1:0]         idx,
  output logic                        rd_valid,
  output logic                        rd_dirty,
  output logic [TAG_BITS-1:0]         rd_tag,
  output logic [WORDS*DATA_WIDTH-1:0] rd_line,
  input  logic                        line_we,
  input  logic [TAG_BITS-1:0]         line_tag,
  input  logic [WORDS*DATA_WIDTH-1:0] line_data,
  input  logic                        line_dirty,
  input  logic                        word_we,
  input  logic [WSEL_BITS-1:0]        word_sel,
  input  logic [DATA_WIDTH-1:0]       word_data,
  input  logic                        clean_we
);

  logic [NUM_LINES-1:0]                 valid;
  logic [NUM_LINES-1:0]                 dirty;
  logic [TAG_BITS-1:0]                  tags [NUM_LINES];
  logic [WORDS-1:0][DATA_WIDTH-1:0]     data [NUM_LINES];

  assign rd_valid = valid[idx];
  assign rd_dirty = dirty[idx];
  assign rd_tag   = tags[idx];
  assign rd_line  = data[idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
      dirty <= '0;
    end else begin
      if (line_we) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= line_dirty;
      end
      if (word_we)  dirty[idx] <= 1'b1;
      if (clean_we) dirty[idx] <= 1'b0;
    end
  end

  // Tag and data contents are meaningless until valid is set, so no reset.
  always_ff @(posedge clk) begin
    if (line_we) begin
      tags[idx] <= line_tag;
      data[idx] <= line_data;
    end
    if (word_we) data[idx][word_sel] <= word_data;
  end

endmodule

// File: rtl/cache_core.sv
// Direct-mapped write-back, write-allocate cache; one request and one memory transaction at a time.
// Define CACHE_STATS_EN to add saturating hit/miss counters (stat_hits, stat_misses).
module cache_core
  import cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINE_BYTES = 16,
  parameter int NUM_LINES  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      core_req_valid,
  output logic                      core_req_ready,
  input  logic                      core_req_we,
  input  logic [ADDR_WIDTH-1:0]     core_req_addr,
  input  logic [DATA_WIDTH-1:0]     core_req_wdata,
  input  logic [DATA_WIDTH/8-1:0]   core_req_wstrb,
  output logic                      core_resp_valid,
  output logic                      core_resp_is_write,
  output logic [DATA_WIDTH-1:0]     core_resp_rdata,
  output logic [1:0]                core_resp_resp,
  output logic                      mem_req_valid,
  input  logic                      mem_req_ready,
  output logic                      mem_req_we,
  output logic [ADDR_WIDTH-1:0]     mem_req_addr,
  output logic [LINE_BYTES*8-1:0]   mem_req_wline,
  input  logic                      mem_resp_valid,
  input  logic [LINE_BYTES*8-1:0]   mem_resp_rline
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]               stat_hits,
  output logic [31:0]               stat_misses
`endif
);

  localparam int OFF_BITS  = $clog2(LINE_BYTES);
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS  = ADDR_WIDTH - IDX_BITS - OFF_BITS;
  localparam int WORDS     = LINE_BYTES * 8 / DATA_WIDTH;
  localparam int LINE_BITS = LINE_BYTES * 8;
  localparam int BYTE_OFF  = $clog2(DATA_WIDTH / 8);
  localparam int WSEL_BITS = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_t                    state;
  logic                      r_we;
  logic [ADDR_WIDTH-1:0]     r_addr;
  logic [DATA_WIDTH-1:0]     r_wdata;
  logic [DATA_WIDTH/8-1:0]   r_wstrb;
  logic [DATA_WIDTH-1:0]     r_rdata;

  logic [IDX_BITS-1:0]       req_idx;
  logic [TAG_BITS-1:0]       req_tag;
  logic [WSEL_BITS-1:0]      req_word;
  logic [ADDR_WIDTH-1:0]     req_line_addr;

  logic                      rd_valid, rd_dirty;
  logic [TAG_BITS-1:0]       rd_tag;
  logic [LINE_BITS-1:0]      rd_line;

  logic                      hit;
  logic [DATA_WIDTH-1:0]     hit_word, hit_merged, rf_word;
  logic [LINE_BITS-1:0]      rf_line;
  logic                      line_we, word_we, clean_we;

  assign req_idx       = IDX_BITS'(addr_field(MAX_AW'(r_addr), OFF_BITS, IDX_BITS));
  assign req_tag       = TAG_BITS'(addr_field(MAX_AW'(r_addr), OFF_BITS + IDX_BITS, TAG_BITS));
  assign req_word      = WSEL_BITS'(addr_field(MAX_AW'(r_addr), BYTE_OFF, OFF_BITS - BYTE_OFF));
  assign req_line_addr = ADDR_WIDTH'(line_align(MAX_AW'(r_addr), OFF_BITS));

  assign hit        = rd_valid && (rd_tag == req_tag);
  assign hit_word   = rd_line[int'(req_word)*DATA_WIDTH +: DATA_WIDTH];
  assign hit_merged = DATA_WIDTH'(byte_merge(MAX_DW'(hit_word), MAX_DW'(r_wdata),
                                             (MAX_DW/8)'(r_wstrb)));
  assign rf_word    = mem_resp_rline[int'(req_word)*DATA_WIDTH +: DATA_WIDTH];

  // Write-miss data is merged into the refill line so install and update share one edge.
  always_comb begin
    rf_line = mem_resp_rline;
    if (r_we)
      rf_line[int'(req_word)*DATA_WIDTH +: DATA_WIDTH] =
        DATA_WIDTH'(byte_merge(MAX_DW'(rf_word), MAX_DW'(r_wdata), (MAX_DW/8)'(r_wstrb)));
  end

  assign word_we        = (state == LOOKUP) && hit && r_we;
  assign line_we        = (state == RF_WAIT) && mem_resp_valid;
  assign clean_we       = (state == WB_WAIT) && mem_resp_valid;
  assign core_req_ready = (state == IDLE);

  cache_array #(
    .TAG_BITS  (TAG_BITS),
    .IDX_BITS  (IDX_BITS),
    .NUM_LINES (NUM_LINES),
    .DATA_WIDTH(DATA_WIDTH),
    .WORDS     (WORDS),
    .WSEL_BITS (WSEL_BITS)
  ) u_array (
    .clk       (clk),
    .rst_n     (rst_n),
    .idx       (req_idx),
    .rd_valid  (rd_valid),
    .rd_dirty  (rd_dirty),
    .rd_tag    (rd_tag),
    .rd_line   (rd_line),
    .line_we   (line_we),
    .line_tag  (req_tag),
    .line_data (rf_line),
    .line_dirty(r_we),
    .word_we   (word_we),
    .word_sel  (req_word),
    .word_data (hit_merged),
    .clean_we  (clean_we)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      r_we               <= 1'b0;
      r_addr             <= '0;
      r_wdata            <= '0;
      r_wstrb            <= '0;
      r_rdata            <= '0;
      core_resp_valid    <= 1'b0;
      core_resp_is_write <= 1'b0;
      core_resp_rdata    <= '0;
      core_resp_resp     <= RESP_OKAY;
      mem_req_valid      <= 1'b0;
      mem_req_we         <= 1'b0;
      mem_req_addr       <= '0;
      mem_req_wline      <= '0;
    end else begin
      core_resp_valid <= 1'b0;
      case (state)
        IDLE: if (core_req_valid) begin
          r_we    <= core_req_we;
          r_addr  <= core_req_addr;
          r_wdata <= core_req_wdata;
          r_wstrb <= core_req_wstrb;
          state   <= LOOKUP;
        end
        LOOKUP: begin
          if (hit) begin
            if (!r_we) r_rdata <= hit_word;
            state <= RESP;
          end else if (rd_valid && rd_dirty) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b1;
            mem_req_addr  <= {rd_tag, req_idx, OFF_BITS'(0)};
            mem_req_wline <= rd_line;
            state         <= WB_REQ;
          end else begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= req_line_addr;
            state         <= RF_REQ;
          end
        end
        WB_REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state         <= WB_WAIT;
        end
        WB_WAIT: if (mem_resp_valid) begin
          mem_req_valid <= 1'b1;
          mem_req_we    <= 1'b0;
          mem_req_addr  <= req_line_addr;
          state         <= RF_REQ;
        end
        RF_REQ: if (mem_req_ready) begin
          mem_req_valid <= 1'b0;
          state         <= RF_WAIT;
        end
        RF_WAIT: if (mem_resp_valid) begin
          if (!r_we) r_rdata <= rf_word;
          state <= RESP;
        end
        RESP: begin
          core_resp_valid    <= 1'b1;
          core_resp_is_write <= r_we;
          core_resp_rdata    <= r_we ? '0 : r_rdata;
          core_resp_resp     <= RESP_OKAY;
          state              <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_hits   <= '0;
      stat_misses <= '0;
    end else if (state == LOOKUP) begin
      if (hit) begin
        if (stat_hits != '1) stat_hits <= stat_hits + 32'd1;
      end else begin
        if (stat_misses != '1) stat_misses <= stat_misses + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_core.sv
// Directed table-driven bench for cache_core with a 3-cycle line memory model.
module tb_cache_core;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         core_req_valid = 1'b0, core_req_ready, core_req_we = 1'b0;
  logic [31:0]  core_req_addr = '0, core_req_wdata = '0;
  logic [3:0]   core_req_wstrb = '0;
  logic         core_resp_valid, core_resp_is_write;
  logic [31:0]  core_resp_rdata;
  logic [1:0]   core_resp_resp;
  logic         mem_req_valid, mem_req_ready = 1'b1, mem_req_we;
  logic [31:0]  mem_req_addr;
  logic [127:0] mem_req_wline;
  logic         mem_resp_valid;
  logic [127:0] mem_resp_rline;

  always #5 clk = ~clk;

  cache_core dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_valid(core_req_valid), .core_req_ready(core_req_ready),
    .core_req_we(core_req_we), .core_req_addr(core_req_addr),
    .core_req_wdata(core_req_wdata), .core_req_wstrb(core_req_wstrb),
    .core_resp_valid(core_resp_valid), .core_resp_is_write(core_resp_is_write),
    .core_resp_rdata(core_resp_rdata), .core_resp_resp(core_resp_resp),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_wline(mem_req_wline), .mem_resp_valid(mem_resp_valid),
    .mem_resp_rline(mem_resp_rline)
  );

  int total = 0, bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: word i = A000_0000+i, response 3 negedges after the request is seen.
  logic [31:0]  mem [0:1023];
  logic         log_we   [0:63];
  logic [31:0]  log_addr [0:63];
  logic [31:0]  log_w1   [0:63];
  int           log_n = 0;

  initial begin
    int pend, cnt, base;
    logic [127:0] pline;
    pend = 0; cnt = 0; pline = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 + i;
    mem_resp_valid = 1'b0;
    mem_resp_rline = '0;
    forever begin
      @(negedge clk);
      mem_resp_valid = 1'b0;
      if (pend != 0) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          mem_resp_valid = 1'b1;
          mem_resp_rline = pline;
        end
      end else if (mem_req_valid && mem_req_ready) begin
        if (log_n < 64) begin
          log_we[log_n]   = mem_req_we;
          log_addr[log_n] = mem_req_addr;
          log_w1[log_n]   = mem_req_wline[63:32];
          log_n++;
        end
        base = int'(mem_req_addr[11:2]);
        for (int w = 0; w < 4; w++) begin
          if (mem_req_we) mem[base + w] = mem_req_wline[w*32 +: 32];
          else            pline[w*32 +: 32] = mem[base + w];
        end
        pend = 1;
        cnt  = 3;
      end
    end
  end

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, output logic [31:0] rdata,
                        output logic isw, output logic [1:0] resp, output int lat);
    int k;
    lat = -1; rdata = '0; isw = 1'b0; resp = 2'b11;
    k = 0;
    @(negedge clk);
    while (!core_req_ready && k < 100) begin @(negedge clk); k++; end
    if (!core_req_ready) begin
      chk("ready_timeout", 32'(core_req_ready), 32'd1);
      return;
    end
    core_req_valid = 1'b1; core_req_we = we; core_req_addr = addr;
    core_req_wdata = wdata; core_req_wstrb = wstrb;
    @(posedge clk); #1;
    core_req_valid = 1'b0;
    chk("ready_low_busy", 32'(core_req_ready), 32'd0);
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (core_resp_valid) begin
        lat = c; rdata = core_resp_rdata; isw = core_resp_is_write; resp = core_resp_resp;
        break;
      end
    end
    if (lat < 0) chk("resp_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp_rdata;
    int          exp_nreq;
  } vec_t;

  vec_t vecs [14];

  initial begin
    logic [31:0] rd;
    logic        isw;
    logic [1:0]  rs;
    int          lat, n0;

    vecs[0]  = '{1'b0, 32'h040, 32'h0,         4'h0, 32'hA000_0010, 1};
    vecs[1]  = '{1'b0, 32'h040, 32'h0,         4'h0, 32'hA000_0010, 0};
    vecs[2]  = '{1'b1, 32'h044, 32'hDEAD_BEEF, 4'hF, 32'h0,         0};
    vecs[3]  = '{1'b0, 32'h044, 32'h0,         4'h0, 32'hDEAD_BEEF, 0};
    vecs[4]  = '{1'b0, 32'h0C0, 32'h0,         4'h0, 32'hA000_0030, 2};
    vecs[5]  = '{1'b0, 32'h044, 32'h0,         4'h0, 32'hDEAD_BEEF, 1};
    vecs[6]  = '{1'b1, 32'h048, 32'h1122_3344, 4'h3, 32'h0,         0};
    vecs[7]  = '{1'b0, 32'h048, 32'h0,         4'h0, 32'hA000_3344, 0};
    vecs[8]  = '{1'b1, 32'h104, 32'h5555_6666, 4'hC, 32'h0,         1};
    vecs[9]  = '{1'b0, 32'h104, 32'h0,         4'h0, 32'h5555_0041, 0};
    vecs[10] = '{1'b1, 32'h208, 32'h7777_8888, 4'h0, 32'h0,         2};
    vecs[11] = '{1'b0, 32'h208, 32'h0,         4'h0, 32'hA000_0082, 0};
    vecs[12] = '{1'b0, 32'h100, 32'h0,         4'h0, 32'hA000_0040, 2};
    vecs[13] = '{1'b0, 32'h104, 32'h0,         4'h0, 32'h5555_0041, 0};

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(core_req_ready), 32'd1);
    chk("rst_resp_valid", 32'(core_resp_valid), 32'd0);
    chk("rst_mem_valid", 32'(mem_req_valid), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      n0 = log_n;
      do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, rd, isw, rs, lat);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("v%0d_is_write", i), 32'(isw), 32'(vecs[i].we));
      chk($sformatf("v%0d_resp", i), 32'(rs), 32'd0);
      chk($sformatf("v%0d_nreq", i), 32'(log_n - n0), 32'(vecs[i].exp_nreq));
      if (vecs[i].exp_nreq == 0) chk($sformatf("v%0d_hit_lat", i), 32'(lat), 32'd2);
      if (i == 0 && log_n > n0) begin
        chk("v0_rf_we", 32'(log_we[n0]), 32'd0);
        chk("v0_rf_addr", log_addr[n0], 32'h40);
      end
      if (i == 4 && log_n >= n0 + 2) begin
        chk("v4_wb_we", 32'(log_we[n0]), 32'd1);
        chk("v4_wb_addr", log_addr[n0], 32'h40);
        chk("v4_wb_word1", log_w1[n0], 32'hDEAD_BEEF);
        chk("v4_rf_we", 32'(log_we[n0+1]), 32'd0);
        chk("v4_rf_addr", log_addr[n0+1], 32'hC0);
      end
      if (i == 5 && log_n > n0) chk("v5_rf_only", 32'(log_we[n0]), 32'd0);
      if (i == 10 && log_n >= n0 + 2) begin
        chk("v10_wb_addr", log_addr[n0], 32'h100);
        chk("v10_wb_word1", log_w1[n0], 32'h5555_0041);
      end
    end

    // Abort a refill with reset while RF_WAIT is outstanding.
    n0 = log_n;
    @(negedge clk);
    core_req_valid = 1'b1; core_req_we = 1'b0; core_req_addr = 32'h300; core_req_wstrb = 4'h0;
    @(posedge clk); #1;
    core_req_valid = 1'b0;
    for (int c = 0; c < 50 && log_n == n0; c++) @(negedge clk);
    chk("rst_mid_req_seen", 32'(log_n - n0), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(core_req_ready), 32'd1);
    chk("mid_rst_resp_valid", 32'(core_resp_valid), 32'd0);
    chk("mid_rst_rdata", core_resp_rdata, 32'd0);
    chk("mid_rst_mem_valid", 32'(mem_req_valid), 32'd0);
    chk("mid_rst_mem_addr", mem_req_addr, 32'd0);
    chk("mid_rst_wline", mem_req_wline[31:0] | mem_req_wline[63:32] |
                         mem_req_wline[95:64] | mem_req_wline[127:96], 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("stray_resp_ignored", 32'(core_resp_valid | mem_req_valid), 32'd0);
    end

    n0 = log_n;
    do_req(1'b0, 32'h040, 32'h0, 4'h0, rd, isw, rs, lat);
    chk("post_rst_rdata", rd, 32'hA000_0010);
    chk("post_rst_nreq", 32'(log_n - n0), 32'd1);
    if (log_n > n0) chk("post_rst_rf_addr", log_addr[n0], 32'h40);
    n0 = log_n;
    do_req(1'b0, 32'h048, 32'h0, 4'h0, rd, isw, rs, lat);
    chk("post_rst_lost_dirty", rd, 32'hA000_0012);
    chk("post_rst_hit_nreq", 32'(log_n - n0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_core.md
Name: cache_core

Overview:
Direct-mapped, write-back, write-allocate cache between a single-word core request port and a whole-line memory port.
- Services word reads and byte-strobed writes from a tag/data/valid/dirty array.
- On a miss, writes back a dirty victim line and then refills the line from memory.
- Keeps one memory transaction in flight; blocking, one core request at a time.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, core word width; multiple of 8.
- LINE_BYTES, 16, bytes per line; power of two, at least DATA_WIDTH/8.
- NUM_LINES, 8, number of lines; power of two, at least 2.
- Derived: OFF_BITS=log2(LINE_BYTES), IDX_BITS=log2(NUM_LINES), TAG_BITS=ADDR_WIDTH-IDX_BITS-OFF_BITS, WORDS=LINE_BYTES*8/DATA_WIDTH, LINE_BITS=LINE_BYTES*8.

Ports:
- clk in 1: clock; all logic on the rising edge.
- rst_n in 1: reset, asynchronous, active-low.
- core_req_valid in 1: core request valid.
- core_req_ready out 1: cache can accept a request.
- core_req_we in 1: 1=write, 0=read.
- core_req_addr in ADDR_WIDTH: byte address; bits below the word offset ignored.
- core_req_wdata in DATA_WIDTH: write data.
- core_req_wstrb in DATA_WIDTH/8: byte enables for writes.
- core_resp_valid out 1: one-cycle response pulse.
- core_resp_is_write out 1: response belongs to a write.
- core_resp_rdata out DATA_WIDTH: read data; 0 for writes.
- core_resp_resp out 2: status, always 2'b00 (OKAY).
- mem_req_valid out 1: memory request valid.
- mem_req_ready in 1: memory accepts the request.
- mem_req_we out 1: 1=writeback, 0=refill.
- mem_req_addr out ADDR_WIDTH: line-aligned address; low OFF_BITS are 0.
- mem_req_wline out LINE_BITS: writeback line; word w occupies bits [w*DATA_WIDTH +: DATA_WIDTH].
- mem_resp_valid in 1: one-cycle ack (writeback) or data-valid (refill).
- mem_resp_rline in LINE_BITS: refill line, same word packing as mem_req_wline.

Behaviour:
- Reset: all valid and dirty bits cleared; FSM goes to IDLE; core_resp_valid=0, core_resp_is_write=0, core_resp_rdata=0, core_resp_resp=0, mem_req_valid=0, mem_req_we=0, mem_req_addr=0, mem_req_wline=0. Tag and data arrays are not reset.
- Address split: offset=addr[OFF_BITS-1:0], word=addr[OFF_BITS-1:log2(DATA_WIDTH/8)], index=addr[OFF_BITS+IDX_BITS-1:OFF_BITS], tag=upper bits.
- FSM states: IDLE, LOOKUP, WB_REQ, WB_WAIT, RF_REQ, RF_WAIT, RESP.
- IDLE: core_req_ready=1; ready is 0 in every other state. On valid&&ready, register we, addr, wdata and wstrb, then go to LOOKUP.
- LOOKUP: hit = valid[idx] && tag[idx]==tag.
  - Hit, read: rdata = the addressed word.
  - Hit, write: merge wdata into the addressed word per wstrb and set dirty.
  - Hit, either case: go to RESP. Hit latency is accept edge +2 to resp_valid.
  - Miss with valid&&dirty victim: go to WB_REQ. Other misses go to RF_REQ.
- WB_REQ: mem_req_valid=1, we=1, addr={victim tag, idx, 0}, wline=stored line. Hold until mem_req_ready, then go to WB_WAIT and drop valid.
- WB_WAIT: on mem_resp_valid, clear dirty and go to RF_REQ.
- RF_REQ: mem_req_valid=1, we=0, addr=line_align(req addr). Hold until ready, then go to RF_WAIT.
- RF_WAIT: on mem_resp_valid, install rline, tag and valid=1 with dirty=0.
  - Write request: merge wdata per wstrb into the installed line in the same edge and set dirty=1.
  - Read request: rdata = the addressed word of rline.
  - Then go to RESP.
- RESP: core_resp_valid=1 for exactly one cycle with is_write=we, then go to IDLE. rdata holds its value until the next response.
- mem_resp_valid outside WB_WAIT/RF_WAIT is ignored.
- mem_req fields are stable while valid && !ready.
- A request with wstrb=0 completes normally: it allocates the line, makes no byte change and still sets dirty.
- Reset asserted mid-operation aborts immediately: any in-flight memory response after reset is ignored, and the cache restarts with all lines invalid.

Optional Feature:
- CACHE_STATS_EN defined: adds outputs stat_hits[31:0] and stat_misses[31:0].
  - Counters are incremented in LOOKUP on hit or miss, saturate at all-ones, and reset to 0.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package cache_pkg holds:
  - the state enum (IDLE…RESP);
  - the RESP_OKAY=2'b00 constant;
  - functions for address split/line_align;
  - the byte-merge function (word, wdata, wstrb).
- Sub-module cache_array holds tag/valid/dirty/data storage: async-reset valid and dirty, synchronous line and word writes, combinational read by index.

Test Plan:
All scenarios use default parameters, memory word i preloaded as 32'hA000_0000+i, 3-cycle memory latency, ready always 1.
- Read 0x40 (cold) → one refill at 0x40, rdata=A000_0010; re-read 0x40 → no mem_req, A000_0010, resp_valid at accept+2.
- Write 0x44 data DEAD_BEEF strb F → write ack (is_write=1, resp=00); read 0x44 → DEAD_BEEF with no memory traffic.
- Read 0xC0 (same index 4, different tag) → writeback at 0x40 whose word1=DEAD_BEEF, then refill 0xC0; rdata=A000_0030.
- Read 0x44 → miss, refill returns DEAD_BEEF from memory, no writeback (line clean).
- Write 0x48 data 1122_3344 strb 0011 → read 0x48 = A000_3344.
- Assert rst_n during RF_WAIT → outputs at reset values; the following read of 0x40 misses and refills again.
